keypad_scanner: RTL and testbench

//  Upstream input stage of the MCU: scans a 4-row x 3-column keypad, debounces, encodes one key to 4 bits.
//  key_data drives the MCU input mux at port 0x80; interrupt drives the MCU interrupt pin.
//  One interrupt pulse per debounced press, no auto-repeat. Runs on 100 MHz clk; MCU runs at clk/2.

---
 rtl/keypad_scanner.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Purpose:
//   Input stage for the MCU. Scans a 4-row x 3-column matrix keypad one row
//   at a time, debounces a single key and encodes it to a 4-bit code. Each
//   debounced press produces exactly one fixed-width interrupt pulse. There is
//   no auto-repeat: a key must be released (debounced) before another press
//   can be accepted.
//
// Ports:
//   clk        in   1  system clock (100 MHz)
//   reset      in   1  asynchronous, active-high; clears all state
//   col_n      in   3  keypad columns, active-low, pulled up; [0]=C [1]=A [2]=E
//   row_n      out  4  keypad row drive, active-low, exactly one bit low;
//                      [0]=B [1]=G [2]=F [3]=D
//   key_data   out  4  last accepted key code (0-9, '*'=4'hA, '#'=4'hB)
//   interrupt  out  1  high for INT_CYCLES cycles per accepted press
//   state_dbg  out  3  one-hot FSM state: SCAN=001 DEBOUNCE=010 HELD=100
//
// Parameters:
//   SCAN_CYCLES   clk cycles each row is driven before its columns are sampled
//   DEBOUNCE_CNT  consecutive matching samples to accept a press or a release
//   INT_CYCLES    interrupt pulse width in clk cycles
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_CYCLES  = 100000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int INT_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_data,
    output logic       interrupt,
    output logic [2:0] state_dbg
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int MW = $clog2(DEBOUNCE_CNT + 1);
    localparam int IW = $clog2(INT_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_CNT);
    localparam logic [IW-1:0] INT_LEN    = IW'(INT_CYCLES);

    typedef enum logic [2:0] {
        SCAN     = 3'b001,
        DEBOUNCE = 3'b010,
        HELD     = 3'b100
    } state_t;

    // Registered state
    logic [2:0]    col_meta_q, col_meta_d;
    logic [2:0]    col_sync_q, col_sync_d;
    logic [DW-1:0] dwell_q,    dwell_d;
    state_t        state_q,    state_d;
    logic [1:0]    row_q,      row_d;
    logic [3:0]    row_n_q,    row_n_d;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [1:0]    cand_col_q, cand_col_d;
    logic [MW-1:0] match_q,    match_d;
    logic [MW-1:0] rel_q,      rel_d;
    logic [3:0]    key_data_q, key_data_d;
    logic [IW-1:0] int_cnt_q,  int_cnt_d;
    logic          interrupt_q, interrupt_d;

    logic tick;
    logic cand_low;

    // Key code for a (row, col) position; row 3 holds '*', '0', '#'.
    function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hB;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // True when the selected (active-low) column is pulled low.
    function automatic logic col_is_low(input logic [2:0] cols, input logic [1:0] idx);
        logic low;
        case (idx)
            2'd0:    low = ~cols[0];
            2'd1:    low = ~cols[1];
            2'd2:    low = ~cols[2];
            default: low = 1'b0;
        endcase
        return low;
    endfunction

    assign tick     = (dwell_q == DWELL_LAST);
    assign cand_low = col_is_low(col_sync_q, cand_col_q);

    always_comb begin
        col_meta_d = col_n;
        col_sync_d = col_meta_q;
        // The dwell counter free-runs regardless of FSM state.
        dwell_d    = tick ? '0 : dwell_q + 1'b1;

        state_d    = state_q;
        row_d      = row_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        match_d    = match_q;
        rel_d      = rel_q;
        key_data_d = key_data_q;
        int_cnt_d  = (int_cnt_q != '0) ? int_cnt_q - 1'b1 : '0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (col_sync_q == 3'b111) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        cand_row_d = row_q;
                        // Several keys in the driven row: lowest column wins.
                        if (!col_sync_q[0]) begin
                            cand_col_d = 2'd0;
                        end else if (!col_sync_q[1]) begin
                            cand_col_d = 2'd1;
                        end else begin
                            cand_col_d = 2'd2;
                        end
                        match_d = MW'(1);
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!cand_low) begin
                        // Bounce or short press: drop it and keep scanning.
                        match_d = '0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end else if (match_q + 1'b1 == MATCH_MAX) begin
                        match_d    = '0;
                        rel_d      = '0;
                        key_data_d = encode(cand_row_q, cand_col_q);
                        int_cnt_d  = INT_LEN;
                        state_d    = HELD;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                HELD: begin
                    if (cand_low) begin
                        // Any low sample restarts the release count.
                        rel_d = '0;
                    end else if (rel_q + 1'b1 == MATCH_MAX) begin
                        rel_d   = '0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        rel_d = rel_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SCAN;
                    match_d = '0;
                    rel_d   = '0;
                end
            endcase
        end

        // Pulse stays high while the countdown (after this cycle) is nonzero,
        // giving exactly INT_CYCLES high cycles starting after the start edge.
        interrupt_d = (int_cnt_d != '0);
    end

    // One active-low row select per row index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row_dec
        assign row_n_d[gi] = (row_d != 2'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q  <= 3'b111;
            col_sync_q  <= 3'b111;
            dwell_q     <= '0;
            state_q     <= SCAN;
            row_q       <= 2'd0;
            row_n_q     <= 4'b1110;
            cand_row_q  <= 2'd0;
            cand_col_q  <= 2'd0;
            match_q     <= '0;
            rel_q       <= '0;
            key_data_q  <= 4'h0;
            int_cnt_q   <= '0;
            interrupt_q <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            dwell_q     <= dwell_d;
            state_q     <= state_d;
            row_q       <= row_d;
            row_n_q     <= row_n_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            key_data_q  <= key_data_d;
            int_cnt_q   <= int_cnt_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign row_n     = row_n_q;
    assign key_data  = key_data_q;
    assign interrupt = interrupt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Testbench for keypad_scanner with SCAN_CYCLES=8, DEBOUNCE_CNT=3,
// INT_CYCLES=4. A keypad model connects pressed keys of the driven row to the
// column lines. Expected key codes are pushed into a scoreboard queue when a
// press long enough to be accepted is issued; a monitor pops and compares on
// every interrupt rising edge and checks the pulse width.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN = 8;
    localparam int DB   = 3;
    localparam int INTC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_data;
    logic       interrupt;
    logic [2:0] state_dbg;

    logic [11:0] pressed = '0;   // bit r*3+c = key at (row r, col c) held down

    int checks = 0;
    int errors = 0;

    logic [3:0] sb_q[$];
    logic [2:0] st_log[$];
    logic       log_en  = 1'b0;
    logic [2:0] last_st = 3'b001;
    logic [3:0] exp_key = 4'h0;
    logic [3:0] mon_exp;
    int         width    = 0;
    logic       prev_int = 1'b0;

    keypad_scanner #(
        .SCAN_CYCLES (SCAN),
        .DEBOUNCE_CNT(DB),
        .INT_CYCLES  (INTC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_data (key_data),
        .interrupt(interrupt),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row line to its column line.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference key map from the keypad layout: rows 0-2 hold 1..9, row 3 holds *,0,#.
    function automatic logic [3:0] code_of(input int k);
        int r;
        int c;
        r = k / 3;
        c = k % 3;
        if (r < 3) return 4'(r * 3 + c + 1);
        if (c == 0) return 4'hA;
        if (c == 1) return 4'h0;
        return 4'hB;
    endfunction

    function automatic logic [3:0] row_pattern(input int r);
        logic [3:0] v;
        v    = 4'b1111;
        v[r] = 1'b0;
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected code per interrupt pulse.
    always @(negedge clk) begin
        if (reset) begin
            prev_int = 1'b0;
            width    = 0;
        end else begin
            if (interrupt && !prev_int) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_irq: interrupt=1 key_data=%0h, expected no pulse (t=%0t)",
                             key_data, $time);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("irq_key_data", key_data, mon_exp);
                    $display("irq: key_data=%0h expected=%0h t=%0t", key_data, mon_exp, $time);
                end
                width = 1;
            end else if (interrupt) begin
                width++;
            end else if (prev_int) begin
                chk("irq_width", width, INTC);
            end
            prev_int = interrupt;
        end
    end

    // Records distinct state_dbg values while enabled.
    always @(negedge clk) begin
        if (log_en && state_dbg != last_st) st_log.push_back(state_dbg);
        last_st = state_dbg;
    end

    task automatic long_press(input int k, input int hold, input int gap);
        logic [3:0] c;
        c = code_of(k);
        sb_q.push_back(c);
        exp_key    = c;
        pressed    = '0;
        pressed[k] = 1'b1;
        cyc(hold);
        chk("press_drained", sb_q.size(), 0);
        chk("key_data_held", key_data, c);
        pressed = '0;
        cyc(gap);
        chk("state_after_release", state_dbg, 3'b001);
        chk("key_data_after_release", key_data, c);
        $display("press: key=%0d code=%0h hold=%0d key_data=%0h", k, c, hold, key_data);
    endtask

    task automatic short_press(input int k, input int len, input int gap);
        pressed    = '0;
        pressed[k] = 1'b1;
        cyc(len);
        pressed = '0;
        cyc(gap);
        chk("short_key_data", key_data, exp_key);
        chk("short_state", state_dbg, 3'b001);
        $display("short: key=%0d len=%0d key_data=%0h", k, len, key_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        cyc(3);
        // Reset state
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_key_data", key_data, 4'h0);
        chk("rst_interrupt", interrupt, 0);
        chk("rst_state", state_dbg, 3'b001);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // 1: idle rotation, one row per SCAN cycles, row 3 wraps to row 0
        for (int k = 0; k <= 40; k++) begin
            if (k % 4 == 0) chk("idle_row_n", row_n, row_pattern((k / SCAN) % 4));
            @(posedge clk);
            #1;
        end
        chk("idle_interrupt", interrupt, 0);
        $display("idle: rotation done row_n=%b", row_n);

        // 2: key '5' held, state sequence SCAN->DEBOUNCE->HELD->SCAN
        st_log.delete();
        log_en = 1'b1;
        long_press(4, 200, 60);
        log_en = 1'b0;
        chk("t2_log_len", st_log.size(), 3);
        if (st_log.size() == 3) begin
            chk("t2_log0", st_log[0], 3'b010);
            chk("t2_log1", st_log[1], 3'b100);
            chk("t2_log2", st_log[2], 3'b001);
        end

        // 3: '#' for a single sample on row 3
        n = 0;
        while (row_n != 4'b0111 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("t3_row3_reached", row_n, 4'b0111);
        st_log.delete();
        log_en = 1'b1;
        short_press(11, SCAN, 40);
        log_en = 1'b0;
        chk("t3_log_len", st_log.size(), 2);
        if (st_log.size() == 2) begin
            chk("t3_log0", st_log[0], 3'b010);
            chk("t3_log1", st_log[1], 3'b001);
        end

        // 4: '*' with bouncy release, then '0'
        sb_q.push_back(4'hA);
        exp_key     = 4'hA;
        pressed     = '0;
        pressed[9]  = 1'b1;
        cyc(150);
        chk("t4_star_drained", sb_q.size(), 0);
        chk("t4_star_key", key_data, 4'hA);
        pressed = '0;
        cyc(10);                      // at most two high samples
        pressed[9] = 1'b1;
        cyc(20);
        chk("t4_bounce_still_held", state_dbg, 3'b100);
        pressed = '0;
        cyc(15);
        chk("t4_release_not_yet", state_dbg, 3'b100);
        cyc(25);
        chk("t4_release_done", state_dbg, 3'b001);
        cyc(30);
        long_press(10, 150, 60);

        // 5: '1' and '3' together, lowest column wins
        sb_q.push_back(4'h1);
        exp_key    = 4'h1;
        pressed    = '0;
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        cyc(150);
        chk("t5_drained", sb_q.size(), 0);
        chk("t5_key", key_data, 4'h1);
        pressed = '0;
        cyc(60);
        $display("t5: key_data=%0h", key_data);

        // 6: reset during the interrupt pulse of '9'
        sb_q.push_back(4'h9);
        pressed    = '0;
        pressed[8] = 1'b1;
        n = 0;
        while (!interrupt && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_irq_seen", interrupt, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_interrupt", interrupt, 0);
        chk("t6_rst_key_data", key_data, 4'h0);
        chk("t6_rst_row_n", row_n, 4'b1110);
        chk("t6_rst_state", state_dbg, 3'b001);
        sb_q.delete();
        exp_key = 4'h0;
        pressed = '0;
        cyc(3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_row_after_rst", row_n, 4'b1110);
        repeat (SCAN) @(posedge clk);
        #1;
        chk("t6_scan_resumed", row_n, 4'b1101);
        $display("t6: reset mid-pulse row_n=%b", row_n);

        // Random mix of accepted presses and too-short presses
        for (int i = 0; i < 16; i++) begin
            int k;
            k = $urandom_range(0, 11);
            if ($urandom_range(0, 3) == 0)
                short_press(k, $urandom_range(1, 2 * SCAN - 1), $urandom_range(40, 80));
            else
                long_press(k, $urandom_range(150, 250), $urandom_range(60, 100));
        end

        cyc(20);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
